hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Issue-side register scoreboard for the ARM Cortex-A9 lab pipeline; the producer-tracking counterpart to the EX-stage forwarding logic. At ID→EX issue it records when each destination result becomes forwardable. It stalls ID while any source operand is not yet forwardable (load-use, multi-cycle multiply), on write-after-write ordering hazards, and while the non-pipelined multiplier is occupied. R0 and R15 are never tracked, consistent with the forwarding path.

## Interface
Parameters:
- LOAD_LAT, 1, cycles after issue until a load result is forwardable
- MUL_LAT, 3, cycles after issue until a multiply result is forwardable, and the multiplier occupancy; range 1..7
- CNT_W, 3, counter width; must satisfy 2^CNT_W > max(LOAD_LAT, MUL_LAT)

Ports:
- Reset is synchronous and active-high; one clock.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rn, id_rm, id_rs  in  4 each  source registers
- id_use_rn, id_use_rm, id_use_rs  in  1 each  the matching source is actually read
- id_rd  in  4  destination register
- id_reg_write  in  1  instruction writes id_rd
- id_lat_class  in  2  0 = ALU, 1 = LOAD, 2 = MUL, 3 = treated as MUL
- flush  in  1  branch resolved taken in EX; the IF/ID contents are squashed this cycle
- id_stall  out  1  hold IF/ID and inject a bubble into EX (combinational)
- issue  out  1  instruction moves ID→EX this cycle (combinational)
- pending_mask  out  16  bit r = cnt[r] != 0 (registered state)
- stall_count  out  16  saturating count of stalled cycles

## Operation
- State:
  - cnt[0..15], each CNT_W bits.
  - mul_busy, CNT_W bits.
  - stall_count, 16 bits.
  - cnt[0] and cnt[15] are held at 0 permanently.
- Latency values: lat = 0 for ALU, LOAD_LAT for LOAD, MUL_LAT for MUL and class 3.
- Source hazard, per source s: the hazard is set when id_use_s = 1, s is not 0 or 15, and cnt[s] != 0.
- WAW hazard: set when id_reg_write = 1, id_rd is not 0 or 15, and cnt[id_rd] > lat. This keeps a younger, faster write from completing before an older, slower one.
- Structural hazard: set when the class is MUL (2 or 3) and mul_busy != 0.
- id_stall = id_valid & ~flush & (source hazard | WAW hazard | structural hazard).
- issue = id_valid & ~flush & ~id_stall.
- Per-cycle update, applied when rst = 0:
  - Every cnt[r] that is nonzero decrements by 1. Decrement occurs every cycle, whether or not there is a stall or flush.
  - On issue with id_reg_write set and id_rd not 0 or 15: cnt[id_rd] is loaded with lat, and this load overrides the decrement.
  - On issue of a MUL (class 2 or 3): mul_busy is loaded with MUL_LAT-1. Otherwise a nonzero mul_busy decrements.
  - When id_stall = 1, stall_count increments and holds at 16'hFFFF.
- Flush suppresses issue and stall for the instruction in ID. It does not alter counters: producers older than the branch keep counting.
- Reset:
  - All cnt, mul_busy and stall_count are cleared to 0.
  - pending_mask reads 0.
  - id_stall and issue follow their equations from the cleared state.
  - Reset asserted mid-multiply discards the pending state.

## Timing
- Issue at edge t with lat L: a consumer in ID stalls during cycles t+1 .. t+L and issues in cycle t+L+1.
  - ALU (L = 0): back-to-back dependent issue with no stall; the forwarding unit supplies the value from MEM.
  - LOAD with LOAD_LAT = 1: exactly one stall cycle; the value is forwarded from WB.
  - MUL with MUL_LAT = 3: three stall cycles.
- Two MULs issue no closer than MUL_LAT cycles apart.
- Stall and flush asserted in the same cycle: flush wins. id_stall = 0 and issue = 0, and stall_count does not increment.
- Producer and consumer use the same register through multiple sources: there is a single stall, with no double counting.
- A counter never underflows below 0.

## Test plan
- Load-use:
  - Stimulus: LOAD issues with rd = R3. The next cycle, ID holds ALU with rn = R3, use_rn = 1.
  - Required: id_stall = 1 for exactly 1 cycle, then issue = 1; stall_count = 1.
- MUL dependency, MUL_LAT = 3:
  - Stimulus: MUL rd = R5 issues. ID then holds a consumer with rm = R5.
  - Required: stall for 3 cycles; pending_mask bit 5 is set for 3 cycles, then clears; issue on the 4th cycle.
- WAW:
  - Stimulus: MUL rd = R2 issues. The next cycle, ALU rd = R2 with no source use.
  - Required: stall until cnt[2] = 0; then cnt[2] loads 0 and pending_mask = 0.
- Structural and R0/R15 exemption:
  - Stimulus: MUL rd = R1, then immediately MUL rd = R4 with no dependency.
  - Required: 2 stall cycles from mul_busy.
  - Stimulus: a LOAD rd = R0 followed by a reader of R0; separately a LOAD rd = R15 followed by a reader of R15.
  - Required: 0 stalls in both cases.
- Flush priority:
  - Stimulus: LOAD rd = R7, then a consumer of R7 with flush = 1 in the stall cycle.
  - Required: id_stall = 0, issue = 0, stall_count unchanged, cnt[7] still decrements to 0.
- Reset mid-operation and saturation:
  - Stimulus: rst = 1 one cycle after a MUL issues.
  - Required: pending_mask = 0, mul_busy = 0, stall_count = 0 on the next cycle.
  - Stimulus: force 65536+ stalled cycles.
  - Required: stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard handshake: decoded operand info in, stall/issue decision out.
interface hazard_scoreboard_if;
    logic        id_valid;
    logic [3:0]  id_rn;
    logic [3:0]  id_rm;
    logic [3:0]  id_rs;
    logic        id_use_rn;
    logic        id_use_rm;
    logic        id_use_rs;
    logic [3:0]  id_rd;
    logic        id_reg_write;
    logic [1:0]  id_lat_class;
    logic        flush;
    logic        id_stall;
    logic        issue;
    logic [15:0] pending_mask;
    logic [15:0] stall_count;

    modport master (
        output id_valid, id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
               id_rd, id_reg_write, id_lat_class, flush,
        input  id_stall, issue, pending_mask, stall_count
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
               id_rd, id_reg_write, id_lat_class, flush,
        output id_stall, issue, pending_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Issue-side register scoreboard: per-register cycles-until-forwardable counters,
// load-use / WAW / multiplier-occupancy stall generation and a saturating stall counter.
module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] LOAD_L = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] MUL_L  = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt [16];
    logic [CNT_W-1:0] mul_busy;
    logic [15:0]      stall_cnt;

    logic [CNT_W-1:0] lat;
    logic             is_mul;
    logic             src_haz;
    logic             waw_haz;
    logic             struct_haz;
    logic             stall;
    logic             issue;
    logic             rd_tracked;
    logic [15:0]      mask;

    // R0 and R15 never have a producer in flight as far as forwarding is concerned.
    function automatic logic tracked(input logic [3:0] r);
        return (r != 4'd0) && (r != 4'd15);
    endfunction

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        lat = '0;
        unique case (sb.id_lat_class)
            2'd0:    lat = '0;
            2'd1:    lat = LOAD_L;
            default: lat = MUL_L;
        endcase
        is_mul     = sb.id_lat_class[1];
        rd_tracked = tracked(sb.id_rd);
        src_haz    = (sb.id_use_rn && tracked(sb.id_rn) && cnt[sb.id_rn] != '0)
                  || (sb.id_use_rm && tracked(sb.id_rm) && cnt[sb.id_rm] != '0)
                  || (sb.id_use_rs && tracked(sb.id_rs) && cnt[sb.id_rs] != '0);
        // An older slower write must land before a younger faster one to the same rd.
        waw_haz    = sb.id_reg_write && rd_tracked && (cnt[sb.id_rd] > lat);
        struct_haz = is_mul && (mul_busy != '0);
        stall      = sb.id_valid && !sb.flush && (src_haz || waw_haz || struct_haz);
        issue      = sb.id_valid && !sb.flush && !stall;
        for (int r = 0; r < 16; r++) begin
            mask[r] = (cnt[r] != '0);
        end
    end

    // NOTE: the counter array is small and its contents are live hazard state, so it is
    // reset like ordinary flops rather than left uninitialised like a RAM.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                cnt[r] <= '0;
            end
            mul_busy  <= '0;
            stall_cnt <= '0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                if (r == 0 || r == 15) begin
                    cnt[r] <= '0;
                end else if (issue && sb.id_reg_write && sb.id_rd == 4'(r)) begin
                    cnt[r] <= lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - ONE;
                end
            end

            if (issue && is_mul) begin
                mul_busy <= MUL_L - ONE;
            end else if (mul_busy != '0) begin
                mul_busy <= mul_busy - ONE;
            end

            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign sb.id_stall     = stall;
    assign sb.issue        = issue;
    assign sb.pending_mask = mask;
    assign sb.stall_count  = stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset/saturation sequences and
// random stimulus against a ready-time reference model.
module tb_hazard_scoreboard;
    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT  = 3;

    typedef struct {
        logic       valid;
        logic [1:0] cls;
        logic [3:0] rd;
        logic       wr;
        logic [3:0] rn;
        logic       urn;
        logic [3:0] rm;
        logic       urm;
        logic [3:0] rs;
        logic       urs;
        logic       flush;
        logic       rst;
    } in_t;

    typedef struct {
        in_t         in;
        logic        stall;
        logic        issue;
        logic [15:0] mask;
        logic [15:0] scnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic sat_rst;
    logic sat_done = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    hazard_scoreboard_if sb_if ();
    hazard_scoreboard_if sat_if ();

    hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    // Self-dependent 15-cycle load keeps this copy stalled 15 of every 16 cycles.
    hazard_scoreboard #(.LOAD_LAT(15), .MUL_LAT(3), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (sat_rst),
        .sb  (sat_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute cycle at which each register / the multiplier becomes free.
    int          now = 0;
    int          ready_at [16];
    int          mul_free = 0;
    int          m_scnt = 0;
    logic        m_stall;
    logic        m_issue;
    logic [15:0] m_mask;

    function automatic int lat_of(input logic [1:0] c);
        return (c == 2'd0) ? 0 : (c == 2'd1) ? LOAD_LAT : MUL_LAT;
    endfunction

    function automatic logic reg_busy(input logic used, input logic [3:0] r);
        return used && r != 4'd0 && r != 4'd15 && ready_at[r] > now;
    endfunction

    task automatic model_cycle(input in_t in);
        int  lat;
        int  remaining;
        logic haz;
        lat       = lat_of(in.cls);
        remaining = (ready_at[in.rd] > now) ? ready_at[in.rd] - now : 0;
        haz = reg_busy(in.urn, in.rn) || reg_busy(in.urm, in.rm) || reg_busy(in.urs, in.rs)
           || (in.wr && in.rd != 4'd0 && in.rd != 4'd15 && remaining > lat)
           || (in.cls[1] && mul_free > now);
        m_stall = in.valid && !in.flush && haz;
        m_issue = in.valid && !in.flush && !haz;
        for (int r = 0; r < 16; r++) m_mask[r] = (ready_at[r] > now);
        if (in.rst) begin
            for (int r = 0; r < 16; r++) ready_at[r] = 0;
            mul_free = 0;
            m_scnt   = 0;
        end else begin
            if (m_issue && in.wr && in.rd != 4'd0 && in.rd != 4'd15) ready_at[in.rd] = now + 1 + lat;
            if (m_issue && in.cls[1]) mul_free = now + MUL_LAT;
            if (m_stall && m_scnt < 16'hFFFF) m_scnt++;
        end
        now++;
    endtask

    task automatic apply(input in_t in);
        sb_if.id_valid     = in.valid;
        sb_if.id_lat_class = in.cls;
        sb_if.id_rd        = in.rd;
        sb_if.id_reg_write = in.wr;
        sb_if.id_rn        = in.rn;
        sb_if.id_use_rn    = in.urn;
        sb_if.id_rm        = in.rm;
        sb_if.id_use_rm    = in.urm;
        sb_if.id_rs        = in.rs;
        sb_if.id_use_rs    = in.urs;
        sb_if.flush        = in.flush;
        rst                = in.rst;
    endtask

    // Drives one cycle; the caller compares outputs before the following rising edge.
    logic [15:0] pre_scnt;
    task automatic run_cycle(input in_t in);
        @(negedge clk);
        apply(in);
        #1;
        pre_scnt = 16'(m_scnt);
        model_cycle(in);
    endtask

    function automatic in_t mk_in(input logic v, input logic [1:0] c, input logic [3:0] rd,
                                  input logic wr, input logic [3:0] rn, input logic urn,
                                  input logic [3:0] rm, input logic urm, input logic [3:0] rs,
                                  input logic urs, input logic fl, input logic rs_t);
        in_t i;
        i.valid = v;  i.cls = c;  i.rd = rd;  i.wr = wr;
        i.rn = rn;    i.urn = urn; i.rm = rm; i.urm = urm;
        i.rs = rs;    i.urs = urs; i.flush = fl; i.rst = rs_t;
        return i;
    endfunction

    function automatic vec_t mk(input in_t i, input logic st, input logic is,
                                input logic [15:0] mask, input logic [15:0] scnt);
        vec_t v;
        v.in = i; v.stall = st; v.issue = is; v.mask = mask; v.scnt = scnt;
        return v;
    endfunction

    function automatic logic [3:0] pick_reg();
        logic [3:0] pool [8];
        pool = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd15};
        return pool[$urandom_range(0, 7)];
    endfunction

    vec_t tbl [$];
    in_t  idle;

    initial begin
        in_t ld3, use3, mul5, use5, mul2, alu2, mul1, mul4;
        idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld3  = mk_in(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        use3 = mk_in(1, 0, 6, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        mul5 = mk_in(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        use5 = mk_in(1, 0, 8, 1, 5, 1, 5, 1, 5, 1, 0, 0);
        mul2 = mk_in(1, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        alu2 = mk_in(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        mul1 = mk_in(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        mul4 = mk_in(1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // load-use: one stall
        tbl.push_back(mk(ld3,  0, 1, 16'h0000, 0));
        tbl.push_back(mk(use3, 1, 0, 16'h0008, 0));
        tbl.push_back(mk(use3, 0, 1, 16'h0000, 1));
        // multiply feeding all three sources: three stalls, counted once each
        tbl.push_back(mk(mul5, 0, 1, 16'h0000, 1));
        tbl.push_back(mk(use5, 1, 0, 16'h0020, 1));
        tbl.push_back(mk(use5, 1, 0, 16'h0020, 2));
        tbl.push_back(mk(use5, 1, 0, 16'h0020, 3));
        tbl.push_back(mk(use5, 0, 1, 16'h0000, 4));
        // WAW behind a multiply
        tbl.push_back(mk(mul2, 0, 1, 16'h0000, 4));
        tbl.push_back(mk(alu2, 1, 0, 16'h0004, 4));
        tbl.push_back(mk(alu2, 1, 0, 16'h0004, 5));
        tbl.push_back(mk(alu2, 1, 0, 16'h0004, 6));
        tbl.push_back(mk(alu2, 0, 1, 16'h0000, 7));
        tbl.push_back(mk(idle, 0, 0, 16'h0000, 7));
        // structural: back-to-back independent multiplies (second uses class 3)
        tbl.push_back(mk(mul1, 0, 1, 16'h0000, 7));
        tbl.push_back(mk(mul4, 1, 0, 16'h0002, 7));
        tbl.push_back(mk(mul4, 1, 0, 16'h0002, 8));
        tbl.push_back(mk(mul4, 0, 1, 16'h0002, 9));
        tbl.push_back(mk(idle, 0, 0, 16'h0010, 9));
        tbl.push_back(mk(idle, 0, 0, 16'h0010, 9));
        tbl.push_back(mk(idle, 0, 0, 16'h0010, 9));
        tbl.push_back(mk(idle, 0, 0, 16'h0000, 9));
        // R0 / R15 never tracked
        tbl.push_back(mk(mk_in(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 16'h0000, 9));
        tbl.push_back(mk(mk_in(1, 0, 6, 1, 0, 1, 0, 1, 0, 0, 0, 0), 0, 1, 16'h0000, 9));
        tbl.push_back(mk(mk_in(1, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 16'h0000, 9));
        tbl.push_back(mk(mk_in(1, 0, 6, 1, 15, 1, 0, 0, 15, 1, 0, 0), 0, 1, 16'h0000, 9));
        // flush beats a load-use stall; counter still drains
        tbl.push_back(mk(mk_in(1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 16'h0000, 9));
        tbl.push_back(mk(mk_in(1, 0, 10, 1, 7, 1, 0, 0, 0, 0, 1, 0), 0, 0, 16'h0080, 9));
        tbl.push_back(mk(idle, 0, 0, 16'h0000, 9));
        tbl.push_back(mk(mk_in(1, 0, 11, 1, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 16'h0000, 9));
        // WAW with equal latency is not a hazard
        tbl.push_back(mk(mk_in(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 16'h0000, 9));
        tbl.push_back(mk(mk_in(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 16'h0200, 9));
        tbl.push_back(mk(idle, 0, 0, 16'h0200, 9));
        tbl.push_back(mk(idle, 0, 0, 16'h0000, 9));

        // reset
        apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) run_cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            run_cycle(tbl[i].in);
            check($sformatf("tbl%0d id_stall", i), 32'(sb_if.id_stall), 32'(tbl[i].stall));
            check($sformatf("tbl%0d issue", i), 32'(sb_if.issue), 32'(tbl[i].issue));
            check($sformatf("tbl%0d pending_mask", i), 32'(sb_if.pending_mask), 32'(tbl[i].mask));
            check($sformatf("tbl%0d stall_count", i), 32'(sb_if.stall_count), 32'(tbl[i].scnt));
        end

        // reset one cycle after a multiply issues
        run_cycle(mul5);
        check("rstmid mul issue", 32'(sb_if.issue), 32'd1);
        run_cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        check("rstmid mask before", 32'(sb_if.pending_mask), 32'h0020);
        check("rstmid scnt before", 32'(sb_if.stall_count), 32'd9);
        run_cycle(mk_in(1, 2, 6, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        check("rstmid mask after", 32'(sb_if.pending_mask), 32'h0000);
        check("rstmid scnt after", 32'(sb_if.stall_count), 32'd0);
        check("rstmid mul_busy cleared", 32'(sb_if.id_stall), 32'd0);
        check("rstmid mul reissue", 32'(sb_if.issue), 32'd1);

        // random traffic against the ready-time model
        for (int n = 0; n < 3000; n++) begin
            in_t r;
            r = mk_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pick_reg(),
                      1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 1)),
                      pick_reg(), 1'($urandom_range(0, 1)), pick_reg(),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 127) == 0));
            run_cycle(r);
            check("rand id_stall", 32'(sb_if.id_stall), 32'(m_stall));
            check("rand issue", 32'(sb_if.issue), 32'(m_issue));
            check("rand pending_mask", 32'(sb_if.pending_mask), 32'(m_mask));
            check("rand stall_count", 32'(sb_if.stall_count), 32'(pre_scnt));
        end

        @(negedge clk);
        apply(idle);
        wait (sat_done);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Saturation: 15 stalls per 16 cycles, so 65535 is reached after 69904 cycles.
    initial begin
        sat_if.id_valid     = 1'b1;
        sat_if.id_lat_class = 2'd1;
        sat_if.id_rd        = 4'd5;
        sat_if.id_reg_write = 1'b1;
        sat_if.id_rn        = 4'd5;
        sat_if.id_use_rn    = 1'b1;
        sat_if.id_rm        = 4'd0;
        sat_if.id_use_rm    = 1'b0;
        sat_if.id_rs        = 4'd0;
        sat_if.id_use_rs    = 1'b0;
        sat_if.flush        = 1'b0;
        sat_rst             = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sat_rst = 1'b0;
        #1;
        check("sat reset count", 32'(sat_if.stall_count), 32'd0);
        repeat (1600) @(posedge clk);
        #1;
        check("sat count 1600 cycles", 32'(sat_if.stall_count), 32'd1500);
        repeat (70000 - 1600) @(posedge clk);
        #1;
        check("sat count saturated", 32'(sat_if.stall_count), 32'hFFFF);
        repeat (40) @(posedge clk);
        #1;
        check("sat count holds", 32'(sat_if.stall_count), 32'hFFFF);
        sat_done = 1'b1;
    end
endmodule
